// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU function codes,
// immediate formats and the raw immediate extractor.
package decode_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // funct7 values accepted by R-type and shift-immediate encodings
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // ALU function codes
   localparam logic [3:0] FC_ADD   = 4'd0;
   localparam logic [3:0] FC_SUB   = 4'd1;
   localparam logic [3:0] FC_SLL   = 4'd2;
   localparam logic [3:0] FC_SLT   = 4'd3;
   localparam logic [3:0] FC_SLTU  = 4'd4;
   localparam logic [3:0] FC_XOR   = 4'd5;
   localparam logic [3:0] FC_SRL   = 4'd6;
   localparam logic [3:0] FC_SRA   = 4'd7;
   localparam logic [3:0] FC_OR    = 4'd8;
   localparam logic [3:0] FC_AND   = 4'd9;
   localparam logic [3:0] FC_PASSB = 4'd10;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_e;

   // 32-bit sign-extended immediate for the given format; R-type/unknown give 0
   function automatic logic [31:0] imm32(input logic [31:0] w, input imm_fmt_e fmt);
      case (fmt)
         IMM_I:   return {{20{w[31]}}, w[31:20]};
         IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
         IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         IMM_U:   return {w[31:12], 12'b0};
         IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave = the decode stage itself, master = the surrounding pipeline.
interface decode_stage_if #(
   parameter int XLEN   = 32,
   parameter int FC_W   = 4,
   parameter int RIDX_W = 5
);
   logic              IN_VALID;
   logic              IN_READY;
   logic [31:0]       INSTR;
   logic              OUT_VALID;
   logic              OUT_READY;
   logic [FC_W-1:0]   FC;
   logic              WREG;
   logic              WMEM;
   logic              RMEM;
   logic              BRANCH;
   logic              JUMP;
   logic              ALU_SRC;
   logic [2:0]        FUNCT3;
   logic [RIDX_W-1:0] RD;
   logic [RIDX_W-1:0] RS1;
   logic [RIDX_W-1:0] RS2;
   logic [XLEN-1:0]   IMM;
   logic              ILLEGAL;

   modport slave (
      input  IN_VALID, INSTR, OUT_READY,
      output IN_READY, OUT_VALID, FC, WREG, WMEM, RMEM, BRANCH, JUMP, ALU_SRC,
             FUNCT3, RD, RS1, RS2, IMM, ILLEGAL
   );

   modport master (
      output IN_VALID, INSTR, OUT_READY,
      input  IN_READY, OUT_VALID, FC, WREG, WMEM, RMEM, BRANCH, JUMP, ALU_SRC,
             FUNCT3, RD, RS1, RS2, IMM, ILLEGAL
   );
endinterface

// File: rtl/decode_stage_comb.sv
// Purely combinational RV32I decoder: instruction word -> full decoded bundle.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int FC_W   = 4,
   parameter int RIDX_W = 5
) (
   input  logic [31:0]       instr_i,
   output logic [FC_W-1:0]   fc_o,
   output logic              wreg_o,
   output logic              wmem_o,
   output logic              rmem_o,
   output logic              branch_o,
   output logic              jump_o,
   output logic              alu_src_o,
   output logic [2:0]        funct3_o,
   output logic [RIDX_W-1:0] rd_o,
   output logic [RIDX_W-1:0] rs1_o,
   output logic [RIDX_W-1:0] rs2_o,
   output logic [XLEN-1:0]   imm_o,
   output logic              illegal_o
);

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [4:0] rd;

   logic [3:0] fc;
   logic       wreg;
   logic       wmem;
   logic       rmem;
   logic       branch;
   logic       jump;
   logic       alu_src;
   logic       illegal;
   imm_fmt_e   fmt;

   assign opc = instr_i[6:0];
   assign rd  = instr_i[11:7];
   assign f3  = instr_i[14:12];
   assign f7  = instr_i[31:25];

   // Widen a 32-bit immediate to XLEN by replicating bit 31
   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i++) begin
         r[i] = (i < 32) ? v[i] : v[31];
      end
      return r;
   endfunction

   // ALU op for the register/immediate arithmetic group; alt selects SUB/SRA
   function automatic logic [3:0] alu_fc(input logic [2:0] f, input logic alt);
      case (f)
         3'b000:  return alt ? FC_SUB : FC_ADD;
         3'b001:  return FC_SLL;
         3'b010:  return FC_SLT;
         3'b011:  return FC_SLTU;
         3'b100:  return FC_XOR;
         3'b101:  return alt ? FC_SRA : FC_SRL;
         3'b110:  return FC_OR;
         default: return FC_AND;
      endcase
   endfunction

   // Classify the opcode, pick ALU op / enables / immediate format, flag illegal encodings
   always_comb begin
      fc      = FC_ADD;
      wreg    = 1'b0;
      wmem    = 1'b0;
      rmem    = 1'b0;
      branch  = 1'b0;
      jump    = 1'b0;
      alu_src = 1'b0;
      illegal = 1'b0;
      fmt     = IMM_NONE;
      case (opc)
         OPC_OP: begin
            wreg    = 1'b1;
            fc      = alu_fc(f3, f7[5]);
            // funct7 0100000 is only meaningful for SUB and SRA
            illegal = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
         end
         OPC_OPIMM: begin
            wreg    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_I;
            // ADDI has no subtract form, so only shifts consult imm[10]
            fc      = alu_fc(f3, f7[5] & (f3 == 3'b101));
            if (f3 == 3'b001) begin
               illegal = (f7 != F7_BASE);
            end else if (f3 == 3'b101) begin
               illegal = !((f7 == F7_BASE) || (f7 == F7_ALT));
            end
         end
         OPC_LOAD: begin
            rmem    = 1'b1;
            wreg    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_I;
            illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            wmem    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_S;
            illegal = (f3 > 3'b010);
         end
         OPC_BRANCH: begin
            branch  = 1'b1;
            fc      = FC_SUB;
            fmt     = IMM_B;
            illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_JAL: begin
            jump    = 1'b1;
            wreg    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_J;
         end
         OPC_JALR: begin
            jump    = 1'b1;
            wreg    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_I;
            illegal = (f3 != 3'b000);
         end
         OPC_LUI: begin
            wreg    = 1'b1;
            alu_src = 1'b1;
            fc      = FC_PASSB;
            fmt     = IMM_U;
         end
         OPC_AUIPC: begin
            wreg    = 1'b1;
            alu_src = 1'b1;
            fmt     = IMM_U;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   // An illegal bundle still flows, but must not cause any side effect downstream
   assign fc_o      = illegal ? '0 : FC_W'(fc);
   assign wreg_o    = wreg & ~illegal & (rd != 5'd0);
   assign wmem_o    = wmem & ~illegal;
   assign rmem_o    = rmem & ~illegal;
   assign branch_o  = branch & ~illegal;
   assign jump_o    = jump & ~illegal;
   assign alu_src_o = alu_src & ~illegal;
   assign illegal_o = illegal;
   assign funct3_o  = f3;
   assign rd_o      = RIDX_W'(rd);
   assign rs1_o     = RIDX_W'(instr_i[19:15]);
   assign rs2_o     = RIDX_W'(instr_i[24:20]);
   assign imm_o     = sext32(imm32(instr_i, fmt));

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32I decode stage. One combinational decoder feeds an
// output register (OR) and a skid register (SK) so IN_READY depends only on state.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int FC_W   = 4,
   parameter int RIDX_W = 5
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           FLUSH,
   decode_stage_if.slave  bus
);

   // Packed bundle: {FC, WREG, WMEM, RMEM, BRANCH, JUMP, ALU_SRC, FUNCT3, RD, RS1, RS2, IMM, ILLEGAL}
   localparam int BW = FC_W + 6 + 3 + 3 * RIDX_W + XLEN + 1;

   logic [FC_W-1:0]   dec_fc;
   logic              dec_wreg;
   logic              dec_wmem;
   logic              dec_rmem;
   logic              dec_branch;
   logic              dec_jump;
   logic              dec_alu_src;
   logic [2:0]        dec_funct3;
   logic [RIDX_W-1:0] dec_rd;
   logic [RIDX_W-1:0] dec_rs1;
   logic [RIDX_W-1:0] dec_rs2;
   logic [XLEN-1:0]   dec_imm;
   logic              dec_illegal;
   logic [BW-1:0]     dec_w;

   logic [BW-1:0]     or_q, or_d;
   logic [BW-1:0]     sk_q, sk_d;
   logic              or_vld_q, or_vld_d;
   logic              sk_vld_q, sk_vld_d;

   logic              in_ready;
   logic              accept;
   logic              or_free;

   decode_comb #(
      .XLEN   (XLEN),
      .FC_W   (FC_W),
      .RIDX_W (RIDX_W)
   ) u_comb (
      .instr_i   (bus.INSTR),
      .fc_o      (dec_fc),
      .wreg_o    (dec_wreg),
      .wmem_o    (dec_wmem),
      .rmem_o    (dec_rmem),
      .branch_o  (dec_branch),
      .jump_o    (dec_jump),
      .alu_src_o (dec_alu_src),
      .funct3_o  (dec_funct3),
      .rd_o      (dec_rd),
      .rs1_o     (dec_rs1),
      .rs2_o     (dec_rs2),
      .imm_o     (dec_imm),
      .illegal_o (dec_illegal)
   );

   assign dec_w = {dec_fc, dec_wreg, dec_wmem, dec_rmem, dec_branch, dec_jump, dec_alu_src,
                   dec_funct3, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_illegal};

   // Ready only from registered state: a free skid slot guarantees room for one more word
   assign in_ready = ~sk_vld_q & ~RST;
   assign accept   = bus.IN_VALID & in_ready;
   // OR can take new content when empty or being consumed this cycle
   assign or_free  = ~or_vld_q | bus.OUT_READY;

   // Next-state of the two-entry buffer; flush beats move and accept
   always_comb begin
      or_vld_d = or_vld_q;
      or_d     = or_q;
      sk_vld_d = sk_vld_q;
      sk_d     = sk_q;
      if (FLUSH) begin
         or_vld_d = 1'b0;
         sk_vld_d = 1'b0;
      end else if (or_free) begin
         if (sk_vld_q) begin
            // older skid entry goes first; a new word refills the skid slot
            or_vld_d = 1'b1;
            or_d     = sk_q;
            sk_vld_d = accept;
            if (accept) begin
               sk_d = dec_w;
            end
         end else begin
            or_vld_d = accept;
            if (accept) begin
               or_d = dec_w;
            end
         end
      end else if (accept) begin
         sk_vld_d = 1'b1;
         sk_d     = dec_w;
      end
   end

   // Buffer registers; reset clears both valids and zeroes the visible bundle
   always_ff @(posedge CLK) begin
      if (RST) begin
         or_vld_q <= 1'b0;
         sk_vld_q <= 1'b0;
         or_q     <= '0;
         sk_q     <= '0;
      end else begin
         or_vld_q <= or_vld_d;
         sk_vld_q <= sk_vld_d;
         or_q     <= or_d;
         sk_q     <= sk_d;
      end
   end

   assign bus.IN_READY  = in_ready;
   assign bus.OUT_VALID = or_vld_q;
   assign {bus.FC, bus.WREG, bus.WMEM, bus.RMEM, bus.BRANCH, bus.JUMP, bus.ALU_SRC,
           bus.FUNCT3, bus.RD, bus.RS1, bus.RS2, bus.IMM, bus.ILLEGAL} = or_q;

endmodule
